// File: rtl/pack_tracker_if.sv
// Dispatch, completion and commit signals of the pack-ID tracker.
// The tracker takes the slave side; dispatch, the ALUs and commit act as master.
interface pack_tracker_if;
    logic       dispatch_valid_i;
    logic       dispatch_ready_o;
    logic       ins0_valid_i;
    logic       ins1_valid_i;
    logic [3:0] pack_id_o;
    logic       alu0_done_i;
    logic [4:0] alu0_rob_i;
    logic       alu1_done_i;
    logic [4:0] alu1_rob_i;
    logic       commit_valid_o;
    logic       commit_ready_i;
    logic [3:0] commit_pack_id_o;
    logic [1:0] commit_mask_o;
    logic [4:0] occupancy_o;

    modport slave (
        input  dispatch_valid_i, ins0_valid_i, ins1_valid_i,
        input  alu0_done_i, alu0_rob_i, alu1_done_i, alu1_rob_i,
        input  commit_ready_i,
        output dispatch_ready_o, pack_id_o, commit_valid_o,
        output commit_pack_id_o, commit_mask_o, occupancy_o
    );

    modport master (
        output dispatch_valid_i, ins0_valid_i, ins1_valid_i,
        output alu0_done_i, alu0_rob_i, alu1_done_i, alu1_rob_i,
        output commit_ready_i,
        input  dispatch_ready_o, pack_id_o, commit_valid_o,
        input  commit_pack_id_o, commit_mask_o, occupancy_o
    );
endinterface

// File: rtl/pack_tracker.sv
// Pack-ID tracker: hands out 4-bit pack IDs in order, collects per-slot
// completions from two ALUs and retires packs in order once every valid
// slot of the head pack has completed.
module pack_tracker #(
    parameter int DEPTH = 16
) (
    input  logic          cpu_clk_i,
    input  logic          cpu_rst_ni,
    input  logic          flush_i,
    pack_tracker_if.slave bus
);

    logic [3:0]       head_reg;
    logic [3:0]       tail_reg;
    logic [4:0]       count_reg;
    logic [DEPTH-1:0] alloc_reg;
    logic [1:0]       vmask_reg [DEPTH];
    logic [1:0]       done_reg  [DEPTH];

    logic dispatch_ready;
    logic dispatch_fire;
    logic head_complete;
    logic commit_valid;
    logic commit_fire;

    // Handshake qualifiers; full/empty are distinguished only by count.
    always_comb begin
        dispatch_ready = (count_reg != 5'(DEPTH)) && !flush_i;
        dispatch_fire  = bus.dispatch_valid_i && dispatch_ready;
        head_complete  = ((done_reg[head_reg] & vmask_reg[head_reg]) == vmask_reg[head_reg]);
        commit_valid   = !flush_i && (count_reg != 5'd0) && alloc_reg[head_reg] && head_complete;
        commit_fire    = commit_valid && bus.commit_ready_i;
    end

    assign bus.dispatch_ready_o = dispatch_ready;
    assign bus.pack_id_o        = tail_reg;
    assign bus.commit_valid_o   = commit_valid;
    assign bus.commit_pack_id_o = head_reg;
    assign bus.commit_mask_o    = vmask_reg[head_reg];
    assign bus.occupancy_o      = count_reg;

    // Head/tail pointers and in-flight count; flush returns everything to empty.
    always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
        if (!cpu_rst_ni) begin
            head_reg  <= 4'd0;
            tail_reg  <= 4'd0;
            count_reg <= 5'd0;
        end else if (flush_i) begin
            head_reg  <= 4'd0;
            tail_reg  <= 4'd0;
            count_reg <= 5'd0;
        end else begin
            if (dispatch_fire) tail_reg <= tail_reg + 4'd1;
            if (commit_fire)   head_reg <= head_reg + 4'd1;
            case ({dispatch_fire, commit_fire})
                2'b10:   count_reg <= count_reg + 5'd1;
                2'b01:   count_reg <= count_reg - 5'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Per-entry state. The tail entry is always free when dispatch fires and
    // head == tail only at empty/full, so dispatch and commit never target the
    // same entry in one cycle.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic       hit0;
            logic       hit1;
            logic [1:0] set_bits;

            // Decode both ALU tags against this entry; OR of both ports, masked by valid slots.
            always_comb begin
                hit0     = bus.alu0_done_i && (bus.alu0_rob_i[4:1] == 4'(gi));
                hit1     = bus.alu1_done_i && (bus.alu1_rob_i[4:1] == 4'(gi));
                set_bits = 2'b00;
                if (hit0) set_bits = set_bits | (bus.alu0_rob_i[0] ? 2'b10 : 2'b01);
                if (hit1) set_bits = set_bits | (bus.alu1_rob_i[0] ? 2'b10 : 2'b01);
                set_bits = set_bits & vmask_reg[gi] & {2{alloc_reg[gi]}};
            end

            // Allocate on dispatch, release on commit, otherwise accumulate completions.
            always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
                if (!cpu_rst_ni) begin
                    alloc_reg[gi] <= 1'b0;
                    vmask_reg[gi] <= 2'b00;
                    done_reg[gi]  <= 2'b00;
                end else if (flush_i) begin
                    alloc_reg[gi] <= 1'b0;
                    done_reg[gi]  <= 2'b00;
                end else if (dispatch_fire && (tail_reg == 4'(gi))) begin
                    alloc_reg[gi] <= 1'b1;
                    vmask_reg[gi] <= {bus.ins1_valid_i, bus.ins0_valid_i};
                    done_reg[gi]  <= 2'b00;
                end else if (commit_fire && (head_reg == 4'(gi))) begin
                    alloc_reg[gi] <= 1'b0;
                    done_reg[gi]  <= 2'b00;
                end else begin
                    done_reg[gi]  <= done_reg[gi] | set_bits;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pack_tracker.sv
// Bench for pack_tracker: directed scenarios followed by random traffic,
// all checked against an in-order queue model of packs in flight.
module tb_pack_tracker;

    logic cpu_clk_i  = 1'b0;
    logic cpu_rst_ni = 1'b0;
    logic flush_i    = 1'b0;

    pack_tracker_if bus ();

    pack_tracker #(.DEPTH(16)) dut (
        .cpu_clk_i  (cpu_clk_i),
        .cpu_rst_ni (cpu_rst_ni),
        .flush_i    (flush_i),
        .bus        (bus)
    );

    always #5 cpu_clk_i = ~cpu_clk_i;

    typedef struct {
        logic [3:0] id;
        logic [1:0] mask;
        logic [1:0] done;
    } pack_t;

    pack_t      q[$];
    logic [3:0] m_tail;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_retired = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic m_head_done();
        return (q.size() != 0) && ((q[0].done & q[0].mask) == q[0].mask);
    endfunction

    function automatic logic [3:0] m_head_id();
        return (q.size() != 0) ? q[0].id : m_tail;
    endfunction

    function automatic void m_reset();
        q.delete();
        m_tail = 4'd0;
    endfunction

    function automatic void m_complete(input logic [4:0] tag);
        for (int k = 0; k < q.size(); k++) begin
            if (q[k].id == tag[4:1] && q[k].mask[tag[0]]) begin
                pack_t p = q[k];
                p.done[tag[0]] = 1'b1;
                q[k] = p;
            end
        end
    endfunction

    // Compare all outputs against the model for the inputs currently driven.
    task automatic compare_outputs();
        logic exp_cv;
        exp_cv = !flush_i && m_head_done();
        check("dispatch_ready", 32'(bus.dispatch_ready_o), 32'((q.size() != 16) && !flush_i));
        check("pack_id", 32'(bus.pack_id_o), 32'(m_tail));
        check("occupancy", 32'(bus.occupancy_o), 32'(q.size()));
        check("commit_valid", 32'(bus.commit_valid_o), 32'(exp_cv));
        check("commit_pack_id", 32'(bus.commit_pack_id_o), 32'(m_head_id()));
        if (q.size() != 0) check("commit_mask", 32'(bus.commit_mask_o), 32'(q[0].mask));
    endtask

    // Advance the model across one clock edge using the inputs held at that edge.
    task automatic model_edge();
        logic cv;
        logic rdy;
        cv  = m_head_done();
        rdy = (q.size() != 16);
        if (flush_i) begin
            m_reset();
        end else begin
            if (bus.alu0_done_i) m_complete(bus.alu0_rob_i);
            if (bus.alu1_done_i) m_complete(bus.alu1_rob_i);
            if (cv && bus.commit_ready_i) begin
                void'(q.pop_front());
                n_retired++;
            end
            if (rdy && bus.dispatch_valid_i) begin
                pack_t p;
                p.id   = m_tail;
                p.mask = {bus.ins1_valid_i, bus.ins0_valid_i};
                p.done = 2'b00;
                q.push_back(p);
                m_tail = m_tail + 4'd1;
            end
        end
    endtask

    // One cycle: drive at negedge, compare, then update the model at posedge.
    task automatic step(input logic dv, input logic [1:0] ins, input logic a0d, input logic [4:0] a0r,
                        input logic a1d, input logic [4:0] a1r, input logic cr, input logic fl);
        @(negedge cpu_clk_i);
        bus.dispatch_valid_i = dv;
        bus.ins0_valid_i     = ins[0];
        bus.ins1_valid_i     = ins[1];
        bus.alu0_done_i      = a0d;
        bus.alu0_rob_i       = a0r;
        bus.alu1_done_i      = a1d;
        bus.alu1_rob_i       = a1r;
        bus.commit_ready_i   = cr;
        flush_i              = fl;
        #1;
        compare_outputs();
        @(posedge cpu_clk_i);
        model_edge();
        $display("cyc t=%0t dv=%0b ins=%b a0=%0b/%h a1=%0b/%h cr=%0b fl=%0b occ_model=%0d",
                 $time, dv, ins, a0d, a0r, a1d, a1r, cr, fl, q.size());
    endtask

    function automatic logic [4:0] rand_tag();
        logic [4:0] t;
        t = 5'($urandom);
        if (q.size() != 0 && $urandom_range(3) != 0) begin
            int idx;
            idx = $urandom_range(q.size() - 1);
            t = {q[idx].id, 1'($urandom)};
        end
        return t;
    endfunction

    task automatic rand_step(input int p_disp, input int p_cr, input int p_flush);
        step($urandom_range(99) < p_disp, 2'($urandom),
             $urandom_range(1) == 1, rand_tag(), $urandom_range(1) == 1, rand_tag(),
             $urandom_range(99) < p_cr, $urandom_range(999) < p_flush);
    endtask

    initial begin
        bus.dispatch_valid_i = 1'b0;
        bus.ins0_valid_i     = 1'b0;
        bus.ins1_valid_i     = 1'b0;
        bus.alu0_done_i      = 1'b0;
        bus.alu0_rob_i       = 5'd0;
        bus.alu1_done_i      = 1'b0;
        bus.alu1_rob_i       = 5'd0;
        bus.commit_ready_i   = 1'b0;
        m_reset();
        #22 cpu_rst_ni = 1'b1;

        // Reset values.
        step(0, 2'b00, 0, 5'd0, 0, 5'd0, 0, 0);
        check("reset_mask", 32'(bus.commit_mask_o), 32'd0);

        // Two-slot pack completes only after both slots report.
        step(1, 2'b11, 0, 5'd0, 0, 5'd0, 0, 0);
        step(0, 2'b00, 1, 5'b00000, 0, 5'd0, 0, 0);
        step(0, 2'b00, 0, 5'd0, 0, 5'd0, 0, 0);
        check("half_done_no_commit", 32'(bus.commit_valid_o), 32'd0);
        step(0, 2'b00, 0, 5'd0, 1, 5'b00001, 0, 0);
        step(0, 2'b00, 0, 5'd0, 0, 5'd0, 1, 0);

        // Fill to 16 with no commits, then hold dispatch while the head retires.
        for (int i = 0; i < 16; i++) step(1, 2'b01, 0, 5'd0, 0, 5'd0, 0, 0);
        step(1, 2'b01, 1, {m_head_id(), 1'b0}, 0, 5'd0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 2'b01, 0, 5'd0, 0, 5'd0, 1, 0);

        // Out-of-order completion behind an incomplete head; unallocated tag ignored.
        step(0, 2'b00, 0, 5'd0, 0, 5'd0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 2'b01, 0, 5'd0, 0, 5'd0, 1, 0);
        step(0, 2'b00, 1, 5'b00100, 1, 5'b11110, 1, 0);
        step(0, 2'b00, 1, 5'b00010, 0, 5'd0, 1, 0);
        step(0, 2'b00, 1, 5'b00000, 1, 5'b00001, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 2'b00, 0, 5'd0, 0, 5'd0, 1, 0);
        check("ooo_all_retired", 32'(q.size()), 32'd0);
        check("ooo_occupancy", 32'(bus.occupancy_o), 32'd0);

        // Back-pressure: complete head held for several cycles then released.
        step(1, 2'b00, 0, 5'd0, 0, 5'd0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 2'b10, 0, 5'd0, 0, 5'd0, 0, 0);
        step(0, 2'b00, 0, 5'd0, 0, 5'd0, 1, 0);

        // Flush with dispatch and commit asserted.
        step(1, 2'b11, 0, 5'd0, 0, 5'd0, 1, 1);
        step(0, 2'b00, 0, 5'd0, 0, 5'd0, 0, 0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 1500; i++) rand_step(60, 70, 8);
        for (int i = 0; i < 300; i++) rand_step(90, 20, 0);

        // Asynchronous reset between clock edges.
        @(negedge cpu_clk_i);
        bus.dispatch_valid_i = 1'b0;
        flush_i = 1'b0;
        #2 cpu_rst_ni = 1'b0;
        #1;
        m_reset();
        check("async_rst_occ", 32'(bus.occupancy_o), 32'd0);
        check("async_rst_cv", 32'(bus.commit_valid_o), 32'd0);
        check("async_rst_id", 32'(bus.pack_id_o), 32'd0);
        check("async_rst_cid", 32'(bus.commit_pack_id_o), 32'd0);
        check("async_rst_mask", 32'(bus.commit_mask_o), 32'd0);
        check("async_rst_ready", 32'(bus.dispatch_ready_o), 32'd1);
        @(negedge cpu_clk_i);
        cpu_rst_ni = 1'b1;
        for (int i = 0; i < 200; i++) rand_step(60, 60, 5);

        check("retired_some", 32'(n_retired > 20), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pack_tracker.md
Name: pack_tracker

Overview:
- Allocates 4-bit pack IDs to the dispatch stage. Dispatch uses the ID to write a two-instruction pack into the instruction RAM.
- Records per-slot completion reported by ALU0/ALU1 using the 5-bit ROB tag {pack_id, slot}.
- Retires packs in order once every valid slot has completed, then recycles the ID.
- Acts as the writer-side and retirement owner of the pack-ID space that the ALUs read through.

Parameters:
- DEPTH, 16, number of packs in flight; fixed at 16 to match the 4-bit pack ID.

Ports:
- cpu_clk_i  in  1  clock
- cpu_rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; discards all in-flight packs
- dispatch_valid_i  in  1  dispatch requests a pack ID this cycle
- dispatch_ready_o  out  1  a pack ID is available
- ins0_valid_i  in  1  slot 0 of the dispatched pack holds an instruction
- ins1_valid_i  in  1  slot 1 of the dispatched pack holds an instruction
- pack_id_o  out  4  ID granted to the current dispatch (equals tail)
- alu0_done_i  in  1  ALU0 completion strobe
- alu0_rob_i  in  5  ALU0 completing tag; [4:1] pack, [0] slot
- alu1_done_i  in  1  ALU1 completion strobe
- alu1_rob_i  in  5  ALU1 completing tag; same encoding as alu0_rob_i
- commit_valid_o  out  1  head pack is complete and ready to retire
- commit_ready_i  in  1  commit stage accepts the head pack
- commit_pack_id_o  out  4  head pack ID
- commit_mask_o  out  2  {slot1, slot0} valid mask of the head pack
- occupancy_o  out  5  packs in flight, 0..16

Behaviour:
- State: head[3:0], tail[3:0], count[4:0], and per entry alloc, vmask[1:0], done[1:0].
- Reset (cpu_rst_ni=0, async): head=tail=0, count=0, all alloc/done cleared. Outputs read commit_valid_o=0, occupancy_o=0, pack_id_o=0, commit_pack_id_o=0, commit_mask_o=0, dispatch_ready_o=1.
- dispatch_ready_o = (count!=16) & ~flush_i. pack_id_o = tail. Both outputs are combinational from registers, so an ID is visible before the handshake.
- Dispatch fire = dispatch_valid_i & dispatch_ready_o. On fire, at the clock edge:
  - entry[tail]: alloc=1, vmask={ins1_valid_i, ins0_valid_i}, done=00.
  - tail+=1, wrapping 15->0.
- A dispatch with vmask=00 is legal; the pack is treated as immediately complete.
- Completion: for each ALU port, if done strobe is high, entry is alloc, and vmask[slot]=1, then done[slot] is set at the next edge.
  - Completion to an unallocated entry or an invalid slot is ignored.
  - Both ports may hit the same pack, or the same slot, in one cycle; the result is the OR of both.
- commit_valid_o = (count!=0) & alloc[head] & ((done[head] & vmask[head]) == vmask[head]). Evaluated from registered done, so a completion makes commit_valid_o visible 1 cycle later at the earliest.
- commit_pack_id_o = head; commit_mask_o = vmask[head]. Both hold steady while commit_valid_o=1 and commit_ready_i=0.
- Commit fire = commit_valid_o & commit_ready_i & ~flush_i. On fire: alloc[head]=0, done[head]=00, head+=1 with wrap.
- count update: +1 on dispatch fire only, -1 on commit fire only, unchanged when both fire in the same cycle.
- Full (count=16): dispatch_ready_o=0. A same-cycle commit does not reopen dispatch until the next cycle; there is no combinational ready bypass.
- Empty (count=0): commit_valid_o=0 regardless of stale entry state.
- Wrap-around: head and tail wrap modulo 16. Full versus empty is distinguished only by count.
- flush_i: highest priority. At the next edge head=tail=0, count=0, all alloc/done cleared. Dispatch, commit and completions in the flush cycle are discarded, and commit_valid_o is gated low during flush.
- Reset asserted mid-operation: immediate return to reset state. No partial commit is emitted.
- occupancy_o = count.

Test Plan:
- Reset, then dispatch 1 pack with ins0=1, ins1=1 -> pack_id_o=0, occupancy_o=1. Complete tag 5'b00000 -> commit_valid_o still 0. Complete 5'b00001 -> commit_valid_o=1 one cycle later with commit_pack_id_o=0, commit_mask_o=11.
- Dispatch 16 packs without commits -> dispatch_ready_o=0 and occupancy_o=16. Commit 1 with dispatch_valid_i held -> next cycle ready=1, and the new pack_id_o=0 (wrap) is granted.
- Dispatch packs 0,1,2 (ins0 only). Complete pack 2 then pack 1 -> no commit. Complete pack 0 -> commits of 0,1,2 on consecutive cycles with commit_ready_i=1.
- Hold commit_ready_i=0 with the head complete -> commit_valid_o=1 and commit_pack_id_o stable for 5 cycles, occupancy unchanged. Release -> exactly one retire.
- Dispatch and commit in the same cycle at count=8 -> count stays 8, head and tail both advance. Completion to an unallocated tag 5'b11110 -> no state change.
- 6 packs in flight, assert flush_i together with dispatch and commit -> next cycle occupancy_o=0, pack_id_o=0, commit_valid_o=0. Drop cpu_rst_ni mid-stream -> outputs return to reset values asynchronously.
